vec_store_unit: RTL and testbench

- Downstream of the vector ALU in the execute/memory stage.
- Accepts one V-lane x N-bit result vector with a per-lane write mask and a base address.
- Serialises the vector into LPB-lane beats on a narrow data-memory write port, with an ack-based stall.
- Pulses `done` when the whole vector has been committed.

---
 rtl/vec_store_if.sv | 38 +++
 rtl/vec_store_unit.sv | 102 ++++++++++
 tb/tb_vec_store_unit.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vec_store_if.sv
// Vector store bus: request side (valid/ready + vector, mask, base address) and beat-wide memory write side.
// Latency: none, wiring only.
// Backpressure: in_ready gates requests; mem_ack stalls the current memory beat.
// Ports (the unit's view):
//   in_valid/in_ready/in_data/in_addr/in_mask
//   mem_we/mem_addr/mem_wdata/mem_lane_en/mem_ack
//   busy/done
interface vec_store_if #(
   parameter int N   = 16,
   parameter int V   = 16,
   parameter int LPB = 2,
   parameter int AW  = 16
);
   logic               in_valid;
   logic               in_ready;
   logic [V*N-1:0]     in_data;
   logic [AW-1:0]      in_addr;
   logic [V-1:0]       in_mask;
   logic               mem_we;
   logic [AW-1:0]      mem_addr;
   logic [LPB*N-1:0]   mem_wdata;
   logic [LPB-1:0]     mem_lane_en;
   logic               mem_ack;
   logic               busy;
   logic               done;

   // Requester / memory model side.
   modport master (
      output in_valid, in_data, in_addr, in_mask, mem_ack,
      input  in_ready, mem_we, mem_addr, mem_wdata, mem_lane_en, busy, done
   );

   // Store unit side.
   modport slave (
      input  in_valid, in_data, in_addr, in_mask, mem_ack,
      output in_ready, mem_we, mem_addr, mem_wdata, mem_lane_en, busy, done
   );
endinterface

// File: rtl/vec_store_unit.sv
// Serialises one V-lane masked vector into LPB-lane beats on a narrow memory write port, then pulses done.
// Latency: beats in cycles 1..B after accept, done in cycle B+1, ready again in B+2; each stall adds one cycle.
// Backpressure: in_ready only in IDLE; a written beat holds addr/data/lane_en until mem_ack, masked-off beats take one cycle.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : vec_store_if.slave (request handshake, memory beat port, busy/done status)
module vec_store_unit #(
   parameter int N   = 16,
   parameter int V   = 16,
   parameter int LPB = 2,
   parameter int AW  = 16
) (
   input  logic      clk,
   input  logic      rst_n,
   vec_store_if.slave bus
);
   localparam int B  = V / LPB;
   localparam int BW = (B > 1) ? $clog2(B) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(B - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITE,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [BW-1:0]    r_beat;
   logic [V*N-1:0]   r_data;
   logic [V-1:0]     r_mask;
   logic [AW-1:0]    r_addr;

   logic [LPB*N-1:0] w_beat_data;
   logic [LPB-1:0]   w_beat_en;
   logic             w_in_write;
   logic             w_we;
   logic             w_adv;
   logic             w_last;
   logic             w_accept;

   // Current beat view of the latched vector; lane b*LPB lands in the LSB slot.
   assign w_beat_data = r_data[32'(r_beat) * (LPB*N) +: LPB*N];
   assign w_beat_en   = r_mask[32'(r_beat) * LPB +: LPB];

   assign w_in_write = (r_state == S_WRITE);
   assign w_last     = (r_beat == LAST_BEAT);
   assign w_accept   = (r_state == S_IDLE) && bus.in_valid;
   assign w_we       = w_in_write && (w_beat_en != '0);
   // A fully masked beat never asks memory, so it retires unconditionally after one cycle.
   assign w_adv      = w_in_write && (!w_we || bus.mem_ack);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.in_valid) begin
               // An empty mask skips memory traffic entirely.
               w_state_nxt = (bus.in_mask != '0) ? S_WRITE : S_DONE;
            end
         end
         S_WRITE: begin
            if (w_adv && w_last) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_beat  <= '0;
         r_data  <= '0;
         r_mask  <= '0;
         r_addr  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_data <= bus.in_data;
            r_mask <= bus.in_mask;
            r_addr <= bus.in_addr;
            r_beat <= '0;
         end else if (w_adv && !w_last) begin
            r_beat <= r_beat + BW'(1);
         end
      end
   end

   // Memory outputs derive only from registered state; they read zero outside WRITE so
   // an aborted or finished vector leaves nothing on the port.
   assign bus.mem_we      = w_we;
   assign bus.mem_addr    = w_in_write ? (r_addr + AW'(r_beat)) : '0;
   assign bus.mem_wdata   = w_in_write ? w_beat_data : '0;
   assign bus.mem_lane_en = w_in_write ? w_beat_en : '0;

   assign bus.in_ready = (r_state == S_IDLE);
   assign bus.busy     = (r_state == S_WRITE) || (r_state == S_DONE);
   assign bus.done     = (r_state == S_DONE);
endmodule

// File: tb/tb_vec_store_unit.sv
// Testbench for vec_store_unit: scoreboard of expected memory beats, checked as the unit emits them.
module tb_vec_store_unit;
   localparam int N   = 16;
   localparam int V   = 16;
   localparam int LPB = 2;
   localparam int AW  = 16;
   localparam int B   = V / LPB;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   vec_store_if #(.N(N), .V(V), .LPB(LPB), .AW(AW)) bus ();

   vec_store_unit #(.N(N), .V(V), .LPB(LPB), .AW(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [AW-1:0]    addr;
      logic [LPB*N-1:0] wdata;
      logic [LPB-1:0]   le;
      int               beat;
   } beat_t;

   beat_t exp_q[$];
   int n_checks = 0;
   int n_errors = 0;
   logic [V*N-1:0] vec_a;
   logic [V*N-1:0] vec_b;

   // Expected beats for one request: one entry per beat that has any enabled lane.
   task automatic push_expected(input logic [V*N-1:0] data, input logic [AW-1:0] addr,
                                input logic [V-1:0] mask);
      beat_t e;
      for (int b = 0; b < B; b++) begin
         e.le    = mask[b*LPB +: LPB];
         e.addr  = AW'(addr + b);
         e.wdata = data[b*LPB*N +: LPB*N];
         e.beat  = b;
         if (e.le != '0) exp_q.push_back(e);
      end
   endtask

   // Issue one request and follow it to done. stall_n cycles of mem_ack=0 are applied
   // on beat stall_beat; exp_done is the cycle (edge 0 = accept) where done must show.
   task automatic run_op(input logic [V*N-1:0] data, input logic [AW-1:0] addr,
                         input logic [V-1:0] mask, input int stall_beat, input int stall_n,
                         input int exp_done, input string name);
      int    stalls;
      bit    seen_done;
      beat_t e;
      stalls    = stall_n;
      seen_done = 1'b0;
      push_expected(data, addr, mask);
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL %s ready_before_accept: got %b, expected 1", name, bus.in_ready);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = data;
      bus.in_addr  = addr;
      bus.in_mask  = mask;
      @(posedge clk);
      for (int k = 1; k <= exp_done + 20 && !seen_done; k++) begin
         @(negedge clk);
         if (k == 1) bus.in_valid = 1'b0;
         bus.mem_ack = 1'b1;
         if (bus.mem_we === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL %s extra_write cycle %0d: got addr=%h data=%h en=%b, expected no write",
                        name, k, bus.mem_addr, bus.mem_wdata, bus.mem_lane_en);
            end else begin
               e = exp_q[0];
               if ({bus.mem_addr, bus.mem_wdata, bus.mem_lane_en} !== {e.addr, e.wdata, e.le}) begin
                  n_errors++;
                  $display("FAIL %s beat%0d cycle %0d: got addr=%h data=%h en=%b, expected addr=%h data=%h en=%b",
                           name, e.beat, k, bus.mem_addr, bus.mem_wdata, bus.mem_lane_en,
                           e.addr, e.wdata, e.le);
               end
               if (e.beat == stall_beat && stalls > 0) begin
                  stalls--;
                  bus.mem_ack = 1'b0;
               end else begin
                  void'(exp_q.pop_front());
               end
            end
         end
         if (bus.done === 1'b1) begin
            seen_done = 1'b1;
            n_checks++;
            if (k != exp_done || exp_q.size() != 0 || bus.busy !== 1'b1) begin
               n_errors++;
               $display("FAIL %s done: got cycle %0d pending=%0d busy=%b, expected cycle %0d pending=0 busy=1",
                        name, k, exp_q.size(), bus.busy, exp_done);
            end
         end
      end
      if (!seen_done) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s done_timeout: got no done, expected done in cycle %0d", name, exp_done);
      end
      @(negedge clk);
      n_checks++;
      if ({bus.in_ready, bus.done, bus.busy, bus.mem_we} !== 4'b1000) begin
         n_errors++;
         $display("FAIL %s after_done: got ready/done/busy/we=%b, expected 1000", name,
                  {bus.in_ready, bus.done, bus.busy, bus.mem_we});
      end
      exp_q.delete();
   endtask

   task automatic test_reset();
      logic [AW+LPB*N+LPB+3:0] got;
      logic [AW+LPB*N+LPB+3:0] want;
      rst_n        = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_mask  = '1;
      bus.in_data  = vec_a;
      bus.in_addr  = 16'h1234;
      bus.mem_ack  = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      got  = {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_lane_en, bus.busy, bus.done, bus.in_ready};
      want = '0;
      want[0] = 1'b1;
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL reset_outputs: got %h, expected %h", got, want);
      end
      rst_n        = 1'b1;
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({bus.in_ready, bus.busy, bus.mem_we} !== 3'b100) begin
         n_errors++;
         $display("FAIL reset_no_capture: got ready/busy/we=%b, expected 100",
                  {bus.in_ready, bus.busy, bus.mem_we});
      end
   endtask

   task automatic test_full();
      run_op(vec_a, 16'h0040, 16'hFFFF, -1, 0, 9, "full");
   endtask

   task automatic test_backpressure();
      run_op(vec_a, 16'h0040, 16'hFFFF, 2, 3, 12, "backpressure");
   endtask

   task automatic test_sparse();
      run_op(vec_a, 16'h0040, 16'h0070, -1, 0, 9, "sparse_0070");
      // Lanes 5..7: beat 2 gets only its upper slot, beat 3 both slots.
      run_op(vec_a, 16'h0040, 16'h00E0, -1, 0, 9, "sparse_00E0");
   endtask

   task automatic test_zero_mask();
      run_op(vec_a, 16'h0040, 16'h0000, -1, 0, 1, "zero_mask");
   endtask

   task automatic test_wrap();
      run_op(vec_b, 16'hFFFE, 16'hFFFF, -1, 0, 9, "wrap");
   endtask

   task automatic test_reset_mid();
      int bad;
      bad = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = vec_a;
      bus.in_addr  = 16'h0100;
      bus.in_mask  = 16'hFFFF;
      bus.mem_ack  = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 1) bus.in_valid = 1'b0;
         if (k == 3) begin
            // Competing request while busy; must be ignored.
            bus.in_valid = 1'b1;
            bus.in_data  = vec_b;
            bus.in_addr  = 16'h0200;
         end
         n_checks++;
         if ({bus.mem_we, bus.mem_addr} !== {1'b1, AW'(16'h0100 + k - 1)}) begin
            n_errors++;
            $display("FAIL reset_mid beat%0d: got we=%b addr=%h, expected we=1 addr=%h",
                     k - 1, bus.mem_we, bus.mem_addr, AW'(16'h0100 + k - 1));
         end
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.mem_we, bus.done, bus.in_ready, bus.busy} !== 4'b0010) begin
         n_errors++;
         $display("FAIL reset_mid_abort: got we/done/ready/busy=%b, expected 0010",
                  {bus.mem_we, bus.done, bus.in_ready, bus.busy});
      end
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (bus.mem_we !== 1'b0 || bus.done !== 1'b0 || bus.in_ready !== 1'b1) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_errors++;
         $display("FAIL reset_mid_quiet: got %0d active cycles after abort, expected 0", bad);
      end
      run_op(vec_b, 16'h0300, 16'h0F0F, -1, 0, 9, "after_reset");
   endtask

   initial begin
      for (int k = 0; k < V; k++) begin
         vec_a[k*N +: N] = N'(16'h1000 + k);
         vec_b[k*N +: N] = N'(16'hA500 + 16'h0011 * k);
      end
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_addr  = '0;
      bus.in_mask  = '0;
      bus.mem_ack  = 1'b1;
      test_reset();
      test_full();
      test_backpressure();
      test_sparse();
      test_zero_mask();
      test_wrap();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
